// File: rtl/rv_ex_mem_pipe.sv
// rv_ex_mem_pipe: EX -> MEM pipeline boundary register with a one-entry skid buffer.
//
// The main register drives the mem_* outputs. The skid register catches the one beat that
// EX may still hand over in the same cycle MEM stalls. ex_ready is taken straight from the
// skid valid flop, so a MEM stall never forms a combinational path back into EX.
// The flush input squashes both entries and any beat offered in the same cycle.
//
// Parameters:
//   DW - datapath width of the ALU result and store data
//   RW - register-index width
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   flush           - squash held and incoming beats this cycle
//   ex_valid/ready  - EX-side handshake; ex_* payload inputs
//   mem_valid/ready - MEM-side handshake; mem_* registered payload outputs
//   stall_cnt       - only when RV_EXMEM_PERF_EN is defined: saturating count of cycles
//                     with mem_valid && !mem_ready, cleared by rst only
//
// Build option: define RV_EXMEM_PERF_EN to add the stall_cnt port and counter.

module rv_ex_mem_pipe #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_zflag,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic [DW-1:0] ex_store_data,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_alu_out,
  output logic          mem_zflag,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic [DW-1:0] mem_store_data
`ifdef RV_EXMEM_PERF_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] alu_out;
    logic          zflag;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] store_data;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;

  beat_t in_beat;
  logic  accept;
  logic  drain;

  // x0 is hard-wired to zero, so a write to it is dropped at capture time.
  always_comb begin
    in_beat            = '0;
    in_beat.alu_out    = ex_alu_out;
    in_beat.zflag      = ex_zflag;
    in_beat.rd         = ex_rd;
    in_beat.reg_write  = ex_reg_write && (ex_rd != '0);
    in_beat.mem_read   = ex_mem_read;
    in_beat.mem_write  = ex_mem_write;
    in_beat.store_data = ex_store_data;
  end

  assign ex_ready  = !skid_valid_q;
  assign mem_valid = main_valid_q;
  assign accept    = ex_valid && ex_ready;
  assign drain     = main_valid_q && mem_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Payload is left as-is; the valid bits alone make it invisible.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // ex_ready is low here, so nothing new can arrive; only refill main from skid.
      if (mem_ready) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || mem_ready) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        // MEM stalled this cycle: park the beat, main holds its payload.
        skid_d       = in_beat;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign mem_alu_out    = main_q.alu_out;
  assign mem_zflag      = main_q.zflag;
  assign mem_rd         = main_q.rd;
  assign mem_reg_write  = main_q.reg_write;
  assign mem_mem_read   = main_q.mem_read;
  assign mem_mem_write  = main_q.mem_write;
  assign mem_store_data = main_q.store_data;

`ifdef RV_EXMEM_PERF_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles a valid beat sits unconsumed; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_valid_q && !mem_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv_ex_mem_pipe.sv
module tb_rv_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic        ex_zflag;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_store_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_alu_out;
  logic        mem_zflag;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [31:0] mem_store_data;
`ifdef RV_EXMEM_PERF_EN
  logic [31:0] stall_cnt;
`endif

  rv_ex_mem_pipe #(
    .DW(32),
    .RW(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_out    (ex_alu_out),
    .ex_zflag      (ex_zflag),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_store_data (ex_store_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_alu_out   (mem_alu_out),
    .mem_zflag     (mem_zflag),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_mem_write (mem_mem_write),
    .mem_store_data(mem_store_data)
`ifdef RV_EXMEM_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu_out;
    logic        zflag;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] store_data;
  } beat_t;

  // Reference model: the pipe is an ordered FIFO of at most two beats.
  beat_t       q[$];
  logic [31:0] stall_m;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic beat_t exp_in();
    beat_t b;
    b.alu_out    = ex_alu_out;
    b.zflag      = ex_zflag;
    b.rd         = ex_rd;
    b.reg_write  = ex_reg_write && (ex_rd != 5'd0);
    b.mem_read   = ex_mem_read;
    b.mem_write  = ex_mem_write;
    b.store_data = ex_store_data;
    return b;
  endfunction

  function automatic beat_t dut_out();
    return {mem_alu_out, mem_zflag, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write,
            mem_store_data};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit    acc;
    beat_t b;
    if (rst) begin
      q.delete();
      stall_m = 32'd0;
    end else begin
      if (q.size() > 0 && !mem_ready && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      if (flush) begin
        q.delete();
      end else begin
        acc = ex_valid && (q.size() < 2);
        b   = exp_in();
        if (q.size() > 0 && mem_ready) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
    end
  endtask

  task automatic check_all();
    chk("mem_valid", mem_valid, q.size() > 0);
    chk("ex_ready", ex_ready, q.size() < 2);
    if (q.size() > 0) chk("payload", dut_out(), q[0]);
`ifdef RV_EXMEM_PERF_EN
    chk("stall_cnt", stall_cnt, stall_m);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw);
    ex_valid      = v;
    ex_alu_out    = alu;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_zflag      = (alu == 32'd0);
    ex_mem_read   = alu[0];
    ex_mem_write  = alu[1];
    ex_store_data = ~alu;
  endtask

  initial begin
    stall_m   = 32'd0;
    rst       = 1'b1;
    flush     = 1'b0;
    mem_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1);

    // Reset held two cycles with a valid beat offered
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", mem_valid, 1'b0);
      chk("rst_ready", ex_ready, 1'b1);
      chk("rst_payload", dut_out(), 128'd0);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("idle_after_rst", mem_valid, 1'b0);

    // Streaming at full rate
    mem_ready = 1'b1;
    drive(1'b1, 32'h10, 5'd1, 1'b1); tick(); chk("stream_10", mem_alu_out, 32'h10);
    chk("stream_rdy0", ex_ready, 1'b1);
    drive(1'b1, 32'h20, 5'd2, 1'b1); tick(); chk("stream_20", mem_alu_out, 32'h20);
    chk("stream_v1", mem_valid, 1'b1);
    drive(1'b1, 32'h30, 5'd3, 1'b1); tick(); chk("stream_30", mem_alu_out, 32'h30);
    chk("stream_v2", mem_valid, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick(); chk("stream_end", mem_valid, 1'b0);

    // Skid: two beats into a stalled MEM, then drain in order
    mem_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd4, 1'b1); tick(); chk("skid_a", mem_alu_out, 32'hA);
    drive(1'b1, 32'hB, 5'd5, 1'b1); tick(); chk("skid_hold_a", mem_alu_out, 32'hA);
    chk("skid_full", ex_ready, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick(); chk("skid_stable", mem_alu_out, 32'hA);
    mem_ready = 1'b1;
    tick(); chk("skid_b", mem_alu_out, 32'hB);
    chk("skid_ready", ex_ready, 1'b1);
    tick(); chk("skid_empty", mem_valid, 1'b0);

    // Flush with skid full and a beat offered
    mem_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd4, 1'b1); tick();
    drive(1'b1, 32'hB, 5'd5, 1'b1); tick();
    chk("fl_full", ex_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'hC, 5'd6, 1'b1); tick();
    chk("fl_valid", mem_valid, 1'b0);
    chk("fl_ready", ex_ready, 1'b1);
    flush     = 1'b0;
    mem_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();
    chk("fl_no_c", mem_valid, 1'b0);

    // x0 write guard
    drive(1'b1, 32'h55, 5'd0, 1'b1); tick();
    chk("x0_rw", mem_reg_write, 1'b0);
    chk("x0_alu", mem_alu_out, 32'h55);
    drive(1'b1, 32'h56, 5'd3, 1'b1); tick();
    chk("x3_rw", mem_reg_write, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();

`ifdef RV_EXMEM_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0;
    mem_ready = 1'b0;
    drive(1'b1, 32'h77, 5'd8, 1'b1); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("perf_7", stall_cnt, 32'd7);
    flush     = 1'b1;
    mem_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_flush", stall_cnt, 32'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perf_rst", stall_cnt, 32'd0);
`endif

    // Randomized traffic against the FIFO model
    for (int i = 0; i < 600; i++) begin
      ex_valid      = ($urandom_range(0, 3) != 0);
      mem_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      ex_alu_out    = $urandom;
      ex_zflag      = 1'($urandom);
      ex_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      ex_reg_write  = 1'($urandom);
      ex_mem_read   = 1'($urandom);
      ex_mem_write  = 1'($urandom);
      ex_store_data = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_ex_mem_pipe.md
Name: rv_ex_mem_pipe

Overview:
Pipeline boundary between the execute stage (ALU result, zero flag, control bits) and the memory stage.
- Registers the EX payload with a valid/ready handshake.
- Includes a one-entry skid buffer, so a MEM stall never combinationally reaches EX.
- Supports a synchronous flush, used for branch/exception squash.

Parameters:
DW, 32, datapath width of ALU result and store data.
RW, 5, register-index width.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  squash all held and incoming entries this cycle
ex_valid  input  1  EX presents a valid beat
ex_ready  output  1  pipe can accept a beat this cycle
ex_alu_out  input  DW  ALU result
ex_zflag  input  1  ALU zero flag
ex_rd  input  RW  destination register index
ex_reg_write  input  1  beat writes the register file
ex_mem_read  input  1  beat is a load
ex_mem_write  input  1  beat is a store
ex_store_data  input  DW  store data (rs2 after forwarding)
mem_valid  output  1  MEM-side beat valid
mem_ready  input  1  MEM consumes the beat this cycle
mem_alu_out  output  DW  registered ALU result
mem_zflag  output  1  registered zero flag
mem_rd  output  RW  registered destination index
mem_reg_write  output  1  registered write enable
mem_mem_read  output  1  registered load flag
mem_mem_write  output  1  registered store flag
mem_store_data  output  DW  registered store data

Behaviour:
State and handshake:
- State is a main register (drives the mem_* outputs) and a skid register, each with its own valid bit.
- mem_valid = main_valid.
- ex_ready = !skid_valid. It is a pure function of a flop; it has no combinational path from mem_ready.
- Accept = ex_valid && ex_ready. Drain = mem_valid && mem_ready.

Per-cycle update, in priority order:
1. rst: main_valid = skid_valid = 0; all payload fields = 0. Every output is 0 and ex_ready = 1 in the first cycle after reset.
2. flush: main_valid = skid_valid = 0. Any beat accepted in the same cycle is discarded. Payload contents are don't-care.
3. skid_valid && mem_ready: main <= skid; skid_valid <= 0. No accept is possible because ex_ready = 0.
4. !skid_valid && Accept && (!main_valid || mem_ready): main <= input; main_valid <= 1.
5. !skid_valid && Accept && main_valid && !mem_ready: skid <= input; skid_valid <= 1. The main register holds.
6. No accept && Drain: main_valid <= 0.
7. Otherwise: hold.

Latency and throughput:
- Latency is 1 cycle from accept to mem_valid.
- Sustained throughput is 1 beat/cycle while mem_ready = 1.

Payload rules:
- If ex_rd == 0, reg_write is captured as 0 (x0 is never written). All other fields are captured unmodified.
- The payload must stay stable at the outputs while mem_valid && !mem_ready.
- No beat is duplicated, dropped or reordered, except by flush.

Boundary conditions:
- mem_ready is don't-care when mem_valid = 0.
- A beat with ex_valid = 0 is never captured, whatever the payload values.
- Reset asserted mid-stall clears both entries.
- Flush asserted while the skid is full clears both entries; ex_ready = 1 on the next cycle.

Optional Feature:
Macro: RV_EXMEM_PERF_EN.
- Defined:
  - Adds output port stall_cnt (32 bits).
  - Increments by 1 every cycle where mem_valid && !mem_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: the port and counter do not exist; the rest of the behaviour is identical.

Test Plan:
1. Reset: hold rst 2 cycles with ex_valid = 1 -> mem_valid = 0, all mem_* = 0, ex_ready = 1; the cycle after release is idle.
2. Streaming: mem_ready = 1; send alu_out 0x10, 0x20, 0x30 on consecutive cycles -> mem_alu_out = 0x10, 0x20, 0x30 one cycle later each, mem_valid continuous, ex_ready always 1.
3. Skid: send 0xA then 0xB while mem_ready = 0 -> mem_alu_out holds 0xA, ex_ready = 0 next cycle. Raise mem_ready -> 0xA, then 0xB delivered in order; ex_ready = 1 again after 0xB moves to main.
4. Flush: skid full (0xA, 0xB), assert flush with ex_valid = 1 carrying 0xC -> next cycle mem_valid = 0, ex_ready = 1; 0xC is never observed.
5. x0 guard: ex_rd = 0, ex_reg_write = 1, ex_alu_out = 0x55 -> mem_reg_write = 0, mem_alu_out = 0x55. With ex_rd = 3 -> mem_reg_write = 1.
6. RV_EXMEM_PERF_EN: hold one beat with mem_ready = 0 for 7 cycles -> stall_cnt = 7. Then flush -> stall_cnt still 7. Then rst -> 0.
